// File: rtl/bitserial_master_port.sv
// Per-master front end for the bit-serial bus: command FIFO, single-outstanding req/gnt/ready
// handshake with a watchdog, and an in-order response FIFO back to the host.
module bitserial_master_port #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic                  cmd_we_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  bus_req_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic                  bus_we_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_ready_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_err_i,
    output logic                  busy_o
);
    localparam int unsigned CPW   = $clog2(CMD_DEPTH);
    localparam int unsigned CCW   = CPW + 1;
    localparam int unsigned RPW   = $clog2(RSP_DEPTH);
    localparam int unsigned RCW   = RPW + 1;
    localparam int unsigned WDW   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CMD_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int unsigned RSP_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                  state_q;
    logic [CMD_W-1:0]        cmd_mem [CMD_DEPTH];
    logic [CPW-1:0]          cmd_wr_ptr_q, cmd_rd_ptr_q;
    logic [CCW-1:0]          cmd_count_q;
    logic [RSP_W-1:0]        rsp_mem [RSP_DEPTH];
    logic [RPW-1:0]          rsp_wr_ptr_q, rsp_rd_ptr_q;
    logic [RCW-1:0]          rsp_count_q;
    logic                    bus_req_q, bus_we_q;
    logic [ADDR_WIDTH-1:0]   bus_addr_q;
    logic [DATA_WIDTH-1:0]   bus_wdata_q;
    logic [WDW-1:0]          wdog_q;
    logic [DATA_WIDTH-1:0]   cap_rdata_q;
    logic                    cap_err_q, cap_timeout_q;
    logic                    cmd_push, issue, rsp_push, rsp_pop;

    assign cmd_ready_o = (cmd_count_q != CCW'(CMD_DEPTH));
    assign cmd_push    = cmd_valid_i && cmd_ready_o;
    // Only issue when the response slot for this transaction is already guaranteed.
    assign issue       = (state_q == StIdle) && (cmd_count_q != '0) &&
                         (rsp_count_q < RCW'(RSP_DEPTH));
    assign rsp_push    = (state_q == StDone);
    assign rsp_valid_o = (rsp_count_q != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    assign {rsp_rdata_o, rsp_err_o, rsp_timeout_o} = rsp_mem[rsp_rd_ptr_q];
    assign bus_req_o   = bus_req_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_we_o    = bus_we_q;
    assign busy_o      = (state_q != StIdle);

    always_ff @(posedge clk_i) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr_q] <= {cmd_addr_i, cmd_wdata_i, cmd_we_i};
        if (rsp_push) rsp_mem[rsp_wr_ptr_q] <= {cap_rdata_q, cap_err_q, cap_timeout_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_count_q  <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_count_q  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + CPW'(1);
            if (issue)    cmd_rd_ptr_q <= cmd_rd_ptr_q + CPW'(1);
            if (cmd_push && !issue)      cmd_count_q <= cmd_count_q + CCW'(1);
            else if (!cmd_push && issue) cmd_count_q <= cmd_count_q - CCW'(1);
            if (rsp_push) rsp_wr_ptr_q <= rsp_wr_ptr_q + RPW'(1);
            if (rsp_pop)  rsp_rd_ptr_q <= rsp_rd_ptr_q + RPW'(1);
            if (rsp_push && !rsp_pop)      rsp_count_q <= rsp_count_q + RCW'(1);
            else if (!rsp_push && rsp_pop) rsp_count_q <= rsp_count_q - RCW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            bus_req_q     <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_we_q      <= 1'b0;
            wdog_q        <= '0;
            cap_rdata_q   <= '0;
            cap_err_q     <= 1'b0;
            cap_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        {bus_addr_q, bus_wdata_q, bus_we_q} <= cmd_mem[cmd_rd_ptr_q];
                        bus_req_q <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        wdog_q    <= '0;
                        if (bus_ready_i) begin
                            cap_rdata_q   <= (bus_we_q || bus_err_i) ? '0 : bus_rdata_i;
                            cap_err_q     <= bus_err_i;
                            cap_timeout_q <= 1'b0;
                            state_q       <= StDone;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    wdog_q <= wdog_q + WDW'(1);
                    // A real completion on the expiry edge takes priority over the watchdog.
                    if (bus_ready_i) begin
                        cap_rdata_q   <= (bus_we_q || bus_err_i) ? '0 : bus_rdata_i;
                        cap_err_q     <= bus_err_i;
                        cap_timeout_q <= 1'b0;
                        state_q       <= StDone;
                    end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                        cap_rdata_q   <= '0;
                        cap_err_q     <= 1'b1;
                        cap_timeout_q <= 1'b1;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
